microc_stack: RTL and testbench
===============================

Name: microc_stack

Overview:
- Parametrised successor to the team's single-cycle microcontroller datapath (no data memory).
- Adds a hardware return-address stack, so subroutine call/return work alongside plain jumps.
- Adds sticky stack-error flags and generic data/PC widths.
- Program memory is external: block presents `pc`, consumes `instr` combinationally in the same cycle. Control unit stays external and drives the select/enable strobes.

Parameters:
- DW, 8, datapath/register width (>= 8).
- PCW, 10, program-counter width (<= 10; jump target is instr[PCW-1:0]).
- DEPTH, 8, return-stack entries (power of two, >= 2).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- instr  in  16  instruction word for address `pc`.
- s_inc  in  1  1: pc+1; 0: jump to instr[PCW-1:0].
- s_inm  in  1  1: ALU A = zero-extended instr[11:4], RA2 = instr[3:0].
- we3  in  1  register-file write enable.
- wez  in  1  zero-flag update enable.
- op  in  3  ALU operation.
- s_call  in  1  push pc+1, jump to target.
- s_ret  in  1  pop into pc.
- pc  out  PCW  current program counter.
- opcode  out  6  instr[15:10].
- z  out  1  zero flag.
- c  out  1  carry flag (see Optional Feature).
- ovf  out  1  sticky stack overflow.
- unf  out  1  sticky stack underflow.

Behaviour:
- Reset (sync, high): pc=0, z=0, c=0, sp=0, ovf=0, unf=0. Register contents are not reset; r0 always reads 0 and ignores writes.
- Read/write addressing: RA1=instr[11:8]; RA2=instr[7:4] (or instr[3:0] if s_inm); WA3=instr[3:0].
- Write-back: WD3 = ALU result, written at clock edge when we3=1.
- ALU: A = rd1 or imm, B = rd2.
  - op: 000 A; 001 ~A; 010 A+B; 011 A-B; 100 A&B; 101 A|B; 110 -A; 111 -B.
  - Results are DW bits, modulo 2^DW.
- z: loads (result==0) when wez=1, else holds.
- Next-PC priority: s_ret > s_call > (s_inc ? pc+1 : target). pc+1 wraps modulo 2^PCW.
- Call, not full: stack[sp] <= pc+1, sp++, pc <= target.
- Call, full (sp==DEPTH): pc <= target, no push, ovf <= 1.
- Return, not empty: sp--, pc <= stack[sp-1].
- Return, empty: pc <= pc+1, unf <= 1, sp stays 0.
- s_call and s_ret together: return only, no push.
- ovf/unf clear only on reset.
- Stack ops are independent of we3/wez: a call can also write a register in the same cycle.
- Single-cycle: every state update occurs at the same clock edge. The pc→instr path is combinational, so memory must be asynchronous read.

Optional Feature:
- Macro: MICROC_CARRY_EN.
- Defined:
  - c loads carry-out of add (010) or NOT borrow of sub (011) when wez=1.
  - Other ops leave c cleared to 0 when wez=1.
- Undefined: c is tied to 0 and no carry logic is synthesised.

Decomposition:
- Package microc_pkg:
  - INSTR_W=16.
  - Field positions: OPC_HI/LO, RA1, RA2, WA3, IMM, TGT.
  - ALU op localparams: ALU_PASS, ALU_NOT, ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_NEGA, ALU_NEGB.
- Sub-module microc_ras: the return stack.
  - Inputs: push, pop, din; parameters DEPTH, PCW.
  - Outputs: dout, full, empty, ovf, unf.
  - Reuses existing regfile/alu where widths permit; otherwise inline.

Test Plan:
1. Reset held 2 cycles, then released → pc=0, z=0, ovf=0, unf=0, opcode=instr[15:10].
2. Immediate path: s_inm=1, op=000, we3=1, instr imm=0x2A, WA3=3 → r3=0x2A. Then op=011 with r3-r3, wez=1 → z=1.
3. Call at pc=5 (s_call=1, target 0x40) → pc=0x40. Later s_ret=1 → pc=6. Nested two levels returns in LIFO order.
4. DEPTH+1 consecutive calls → the last call still jumps to its target, ovf=1. DEPTH+1 returns → the first DEPTH pop the correct addresses, the extra gives pc+1 and unf=1.
5. s_call and s_ret together with one stack entry holding 0x12 → pc=0x12, stack empty, no push.
6. With MICROC_CARRY_EN: 0xFF+0x01 with wez=1 → result 0x00, z=1, c=1. Without the macro → c stays 0.

Source files
------------

// File: rtl/microc_pkg.sv
// Shared definitions for the microc_stack datapath: instruction field positions and ALU opcodes.
// Latency: n/a (constants only).
// Backpressure: n/a.
package microc_pkg;

  localparam int INSTR_W = 16;

  // Instruction field positions
  localparam int OPC_HI = 15;
  localparam int OPC_LO = 10;
  localparam int RA1_HI = 11;
  localparam int RA1_LO = 8;
  localparam int RA2_HI = 7;
  localparam int RA2_LO = 4;
  localparam int WA3_HI = 3;
  localparam int WA3_LO = 0;
  localparam int IMM_HI = 11;
  localparam int IMM_LO = 4;
  localparam int TGT_LO = 0;

  // ALU operations
  localparam logic [2:0] ALU_PASS = 3'b000;
  localparam logic [2:0] ALU_NOT  = 3'b001;
  localparam logic [2:0] ALU_ADD  = 3'b010;
  localparam logic [2:0] ALU_SUB  = 3'b011;
  localparam logic [2:0] ALU_AND  = 3'b100;
  localparam logic [2:0] ALU_OR   = 3'b101;
  localparam logic [2:0] ALU_NEGA = 3'b110;
  localparam logic [2:0] ALU_NEGB = 3'b111;

endpackage

// File: rtl/microc_ras.sv
// Return-address stack with sticky overflow/underflow flags.
// Latency: push/pop take effect at the next clock edge; dout_o is the current top, combinational.
// Backpressure: none; a push when full or a pop when empty is dropped and flagged.
//
// Ports:
//   clk_i, reset_i        clock, synchronous active-high reset
//   push_i, pop_i         stack operations; pop wins when both are set (no push)
//   din_i                 address pushed
//   dout_o                top-of-stack entry (valid when !empty_o)
//   full_o, empty_o       occupancy status
//   ovf_o, unf_o          sticky: push while full / pop while empty, cleared only by reset
module microc_ras #(
  parameter int DEPTH = 8,
  parameter int PCW   = 10
) (
  input  logic           clk_i,
  input  logic           reset_i,
  input  logic           push_i,
  input  logic           pop_i,
  input  logic [PCW-1:0] din_i,
  output logic [PCW-1:0] dout_o,
  output logic           full_o,
  output logic           empty_o,
  output logic           ovf_o,
  output logic           unf_o
);

  localparam int AW  = $clog2(DEPTH);
  localparam int SPW = AW + 1;
  localparam logic [SPW-1:0] FULL_SP = SPW'(DEPTH);

  logic [PCW-1:0] mem_q [DEPTH];
  logic [SPW-1:0] sp_q, sp_d, sp_m1;
  logic           ovf_q, ovf_d, unf_q, unf_d;
  logic           push_req, do_push, do_pop;

  assign full_o  = (sp_q == FULL_SP);
  assign empty_o = (sp_q == '0);

  // A simultaneous push and pop is treated as a pop alone.
  assign push_req = push_i & ~pop_i;
  assign do_push  = push_req & ~full_o;
  assign do_pop   = pop_i & ~empty_o;

  assign sp_m1  = sp_q - SPW'(1);
  assign dout_o = mem_q[sp_m1[AW-1:0]];

  always_comb begin
    sp_d  = sp_q;
    ovf_d = ovf_q;
    unf_d = unf_q;
    if (do_pop) begin
      sp_d = sp_m1;
    end else if (do_push) begin
      sp_d = sp_q + SPW'(1);
    end
    if (push_req && full_o) begin
      ovf_d = 1'b1;
    end
    if (pop_i && empty_o) begin
      unf_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      sp_q  <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      sp_q  <= sp_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  // Storage is not reset; only entries below sp are ever read.
  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[sp_q[AW-1:0]] <= din_i;
    end
  end

  assign ovf_o = ovf_q;
  assign unf_o = unf_q;

endmodule

// File: rtl/microc_stack.sv
// Single-cycle microcontroller datapath with register file, ALU, zero/carry flags and hardware return stack.
// Latency: all state updates at one clock edge; pc -> instr -> next state is combinational (async program memory).
// Backpressure: none; stack misuse is absorbed and reported through sticky ovf/unf.
//
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   instr                       instruction at address pc (same cycle)
//   s_inc, s_inm, we3, wez, op  control strobes from the external control unit
//   s_call, s_ret               subroutine call / return
//   pc, opcode                  program counter, instr[15:10]
//   z, c                        zero flag, carry flag
//   ovf, unf                    sticky return-stack overflow / underflow
// Build option: define MICROC_CARRY_EN to implement the carry flag; otherwise c is tied to 0.
module microc_stack
  import microc_pkg::*;
#(
  parameter int DW    = 8,
  parameter int PCW   = 10,
  parameter int DEPTH = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [INSTR_W-1:0] instr,
  input  logic               s_inc,
  input  logic               s_inm,
  input  logic               we3,
  input  logic               wez,
  input  logic [2:0]         op,
  input  logic               s_call,
  input  logic               s_ret,
  output logic [PCW-1:0]     pc,
  output logic [5:0]         opcode,
  output logic               z,
  output logic               c,
  output logic               ovf,
  output logic               unf
);

  logic [3:0]     ra1, ra2, wa3;
  logic [DW-1:0]  rf_q [16];
  logic [DW-1:0]  rd1, rd2, alu_a, alu_res;
  logic [PCW-1:0] pc_q, pc_d, pc_inc, tgt, ras_dout;
  logic           z_q, z_d;
  logic           ras_full, ras_empty;

  // ---------------- register file ----------------
  assign ra1 = instr[RA1_HI:RA1_LO];
  assign ra2 = s_inm ? instr[WA3_HI:WA3_LO] : instr[RA2_HI:RA2_LO];
  assign wa3 = instr[WA3_HI:WA3_LO];

  // r0 is hardwired to zero; writes to it are dropped.
  assign rd1 = (ra1 == 4'd0) ? '0 : rf_q[ra1];
  assign rd2 = (ra2 == 4'd0) ? '0 : rf_q[ra2];

  always_ff @(posedge clk) begin
    if (we3 && (wa3 != 4'd0)) begin
      rf_q[wa3] <= alu_res;
    end
  end

  // ---------------- ALU ----------------
  assign alu_a = s_inm ? DW'(instr[IMM_HI:IMM_LO]) : rd1;

  always_comb begin
    alu_res = '0;
    case (op)
      ALU_PASS: alu_res = alu_a;
      ALU_NOT:  alu_res = ~alu_a;
      ALU_ADD:  alu_res = alu_a + rd2;
      ALU_SUB:  alu_res = alu_a - rd2;
      ALU_AND:  alu_res = alu_a & rd2;
      ALU_OR:   alu_res = alu_a | rd2;
      ALU_NEGA: alu_res = '0 - alu_a;
      ALU_NEGB: alu_res = '0 - rd2;
      default:  alu_res = alu_a;
    endcase
  end

  assign z_d = wez ? (alu_res == '0) : z_q;

`ifdef MICROC_CARRY_EN
  logic [DW:0] add_ext, sub_ext;
  logic        c_q, c_d;

  assign add_ext = {1'b0, alu_a} + {1'b0, rd2};
  assign sub_ext = {1'b0, alu_a} - {1'b0, rd2};

  // Subtraction reports NOT borrow, so c=1 means A >= B.
  always_comb begin
    c_d = c_q;
    if (wez) begin
      case (op)
        ALU_ADD: c_d = add_ext[DW];
        ALU_SUB: c_d = ~sub_ext[DW];
        default: c_d = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      c_q <= 1'b0;
    end else begin
      c_q <= c_d;
    end
  end

  assign c = c_q;
`else
  assign c = 1'b0;
`endif

  // ---------------- return stack ----------------
  microc_ras #(
    .DEPTH (DEPTH),
    .PCW   (PCW)
  ) u_ras (
    .clk_i   (clk),
    .reset_i (reset),
    .push_i  (s_call),
    .pop_i   (s_ret),
    .din_i   (pc_inc),
    .dout_o  (ras_dout),
    .full_o  (ras_full),
    .empty_o (ras_empty),
    .ovf_o   (ovf),
    .unf_o   (unf)
  );

  a_ras_status : assert property (@(posedge clk) !(ras_full && ras_empty));

  // ---------------- program counter ----------------
  assign pc_inc = pc_q + PCW'(1);
  assign tgt    = instr[TGT_LO +: PCW];

  // Return beats call beats sequential/jump; a return on an empty stack just steps on.
  always_comb begin
    pc_d = s_inc ? pc_inc : tgt;
    if (s_call) begin
      pc_d = tgt;
    end
    if (s_ret) begin
      pc_d = ras_empty ? pc_inc : ras_dout;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q <= '0;
      z_q  <= 1'b0;
    end else begin
      pc_q <= pc_d;
      z_q  <= z_d;
    end
  end

  assign pc     = pc_q;
  assign opcode = instr[OPC_HI:OPC_LO];
  assign z      = z_q;

endmodule

// File: tb/tb_microc_stack.sv
module tb_microc_stack;
  import microc_pkg::*;

  localparam int DW    = 8;
  localparam int PCW   = 10;
  localparam int DEPTH = 8;
  localparam int DMASK = 255;
  localparam int PMASK = 1023;
`ifdef MICROC_CARRY_EN
  localparam int CARRY = 1;
`else
  localparam int CARRY = 0;
`endif

  logic           clk = 1'b0;
  logic           reset;
  logic [15:0]    instr;
  logic           s_inc, s_inm, we3, wez, s_call, s_ret;
  logic [2:0]     op;
  logic [PCW-1:0] pc;
  logic [5:0]     opcode;
  logic           z, c, ovf, unf;

  microc_stack #(.DW(DW), .PCW(PCW), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .instr(instr), .s_inc(s_inc), .s_inm(s_inm),
    .we3(we3), .wez(wez), .op(op), .s_call(s_call), .s_ret(s_ret),
    .pc(pc), .opcode(opcode), .z(z), .c(c), .ovf(ovf), .unf(unf)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  int m_rf [16];
  int m_pc, m_z, m_c, m_ovf, m_unf;
  int m_stk [$];

  int n_cmp = 0;
  int n_err = 0;
  bit chk_en = 1'b0;
  int pin_pc = -1, pin_z = -1, pin_c = -1, pin_ovf = -1, pin_unf = -1;

  function automatic int rd(input int idx);
    return (idx == 0) ? 0 : m_rf[idx];
  endfunction

  task automatic model_reset();
    m_pc = 0; m_z = 0; m_c = 0; m_ovf = 0; m_unf = 0;
    m_stk.delete();
    for (int i = 0; i < 16; i++) m_rf[i] = 0;
  endtask

  // Applies one clock edge of architectural behaviour using the current inputs.
  task automatic model_edge();
    int a, b, r, nxt, tgt;
    a = s_inm ? int'(instr[11:4]) : rd(int'(instr[11:8]));
    b = rd(s_inm ? int'(instr[3:0]) : int'(instr[7:4]));
    case (op)
      3'd0: r = a;
      3'd1: r = ~a;
      3'd2: r = a + b;
      3'd3: r = a - b;
      3'd4: r = a & b;
      3'd5: r = a | b;
      3'd6: r = -a;
      default: r = -b;
    endcase
    r = r & DMASK;
    if (wez) begin
      m_z = (r == 0) ? 1 : 0;
      if (CARRY == 1) begin
        if (op == 3'd2)      m_c = (a + b > DMASK) ? 1 : 0;
        else if (op == 3'd3) m_c = (a >= b) ? 1 : 0;
        else                 m_c = 0;
      end
    end
    if (we3 && instr[3:0] != 4'd0) m_rf[instr[3:0]] = r;
    nxt = (m_pc + 1) & PMASK;
    tgt = int'(instr[9:0]);
    if (s_ret) begin
      if (m_stk.size() > 0) m_pc = m_stk.pop_back();
      else begin m_pc = nxt; m_unf = 1; end
    end else if (s_call) begin
      if (m_stk.size() < DEPTH) m_stk.push_back(nxt);
      else m_ovf = 1;
      m_pc = tgt;
    end else begin
      m_pc = s_inc ? nxt : tgt;
    end
  endtask

  // ---------------- single compare process ----------------
  task automatic check(input string nm, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s at t=%0t: got 0x%0h, expected 0x%0h", nm, $time, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("pc", int'(pc), m_pc);
      check("opcode", int'(opcode), int'(instr[15:10]));
      check("z", int'(z), m_z);
      check("c", int'(c), m_c);
      check("ovf", int'(ovf), m_ovf);
      check("unf", int'(unf), m_unf);
      if (pin_pc  >= 0) check("lit_pc",  int'(pc),  pin_pc);
      if (pin_z   >= 0) check("lit_z",   int'(z),   pin_z);
      if (pin_c   >= 0) check("lit_c",   int'(c),   pin_c);
      if (pin_ovf >= 0) check("lit_ovf", int'(ovf), pin_ovf);
      if (pin_unf >= 0) check("lit_unf", int'(unf), pin_unf);
    end
  end

  // ---------------- stimulus helpers ----------------
  function automatic logic [15:0] f_rr(input int ra1, input int ra2, input int wa3);
    return {6'h01, 4'(ra1), 4'(ra2), 4'(wa3)};
  endfunction

  function automatic logic [15:0] f_im(input int imm, input int wa3);
    return {6'h02, 8'(imm), 4'(wa3)};
  endfunction

  function automatic logic [15:0] f_j(input int tgt);
    return {6'h2A, 10'(tgt)};
  endfunction

  task automatic step(input logic [15:0] ins, input logic inc, input logic inm,
                      input logic w3, input logic wz, input logic [2:0] o,
                      input logic cl, input logic rt,
                      input int e_pc = -1, input int e_z = -1, input int e_c = -1,
                      input int e_ovf = -1, input int e_unf = -1);
    instr = ins; s_inc = inc; s_inm = inm; we3 = w3; wez = wz; op = o;
    s_call = cl; s_ret = rt;
    pin_pc = e_pc; pin_z = e_z; pin_c = e_c; pin_ovf = e_ovf; pin_unf = e_unf;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; instr = 16'hFC00; s_inc = 1'b0; s_inm = 1'b0; we3 = 1'b0;
    wez = 1'b0; op = 3'd0; s_call = 1'b0; s_ret = 1'b0;
    // Reset held for two cycles
    @(posedge clk);
    #1;
    model_reset();
    pin_pc = 0; pin_z = 0; pin_c = 0; pin_ovf = 0; pin_unf = 0;
    chk_en = 1'b1;
    @(posedge clk);
    @(negedge clk);
    #1;
    reset = 1'b0;

    // Immediate path and ALU
    step(f_im(8'h2A, 3), 1, 1, 1, 0, ALU_PASS, 0, 0, 1);
    step(f_rr(3, 3, 0),  1, 0, 0, 1, ALU_SUB,  0, 0, 2, 1, CARRY);
    step(f_im(8'h01, 1), 1, 1, 1, 0, ALU_PASS, 0, 0);
    step(f_im(8'hFF, 2), 1, 1, 1, 1, ALU_PASS, 0, 0, 4, 0, 0);
    step(f_rr(2, 1, 4),  1, 0, 1, 1, ALU_ADD,  0, 0, 5, 1, CARRY);
    // Call at pc=5 to 0x40
    step(f_j(10'h040),   0, 0, 0, 0, ALU_PASS, 1, 0, 'h40);
    step(f_rr(3, 1, 0),  1, 0, 0, 1, ALU_AND,  0, 0, -1, 1);
    step(f_rr(3, 1, 0),  1, 0, 0, 1, ALU_OR,   0, 0, -1, 0);
    step(f_rr(2, 0, 0),  1, 0, 0, 1, ALU_NOT,  0, 0, -1, 1);
    step(f_rr(1, 2, 5),  1, 0, 1, 1, ALU_NEGB, 0, 0, -1, 0);
    step(f_rr(5, 1, 0),  1, 0, 0, 1, ALU_SUB,  0, 0, -1, 1, CARRY);
    step(f_rr(1, 2, 0),  1, 0, 0, 1, ALU_SUB,  0, 0, -1, 0, 0);
    step(f_im(8'h55, 0), 1, 1, 1, 0, ALU_PASS, 0, 0);
    step(f_rr(0, 0, 0),  1, 0, 0, 1, ALU_PASS, 0, 0, -1, 1);
    step(f_rr(1, 0, 0),  1, 0, 0, 1, ALU_NEGA, 0, 0, -1, 0);
    step(f_rr(0, 0, 0),  1, 0, 0, 0, ALU_PASS, 0, 1, 6);
    // Nested call/return
    step(f_j(10'h100),   1, 0, 0, 0, ALU_PASS, 1, 0, 'h100);
    step(f_j(10'h200),   1, 0, 0, 0, ALU_PASS, 1, 0, 'h200);
    step(f_rr(0, 0, 0),  1, 0, 0, 0, ALU_PASS, 0, 1, 'h101);
    step(f_rr(0, 0, 0),  1, 0, 0, 0, ALU_PASS, 0, 1, 7);
    // Jump to top of PC space and wrap
    step(f_j(10'h3FF),   0, 0, 0, 0, ALU_PASS, 0, 0, 'h3FF);
    step(f_rr(0, 0, 0),  1, 0, 0, 0, ALU_PASS, 0, 0, 0);
    // DEPTH+1 calls; each also writes an immediate register
    for (int k = 0; k <= DEPTH; k++) begin
      step(f_j(16 + k), 0, 1, 1, 0, ALU_PASS, 1, 0, 16 + k, -1, -1,
           (k == DEPTH) ? 1 : 0, 0);
    end
    // DEPTH+1 returns
    for (int j = 0; j <= DEPTH; j++) begin
      step(f_rr(0, 0, 0), 1, 0, 0, 0, ALU_PASS, 0, 1,
           (j < DEPTH - 1) ? ('h17 - j) : ((j == DEPTH - 1) ? 1 : 2),
           -1, -1, 1, (j == DEPTH) ? 1 : 0);
    end
    // Register written during a call: imm 0x81 - r7 == 0
    step(f_im(8'h81, 7), 1, 1, 0, 1, ALU_SUB, 0, 0, 3, 1, CARRY);
    // Simultaneous call and return with one entry (0x12)
    step(f_j(10'h011),   0, 0, 0, 0, ALU_PASS, 0, 0, 'h11);
    step(f_j(10'h030),   0, 0, 0, 0, ALU_PASS, 1, 0, 'h30);
    step(f_j(10'h050),   0, 0, 0, 0, ALU_PASS, 1, 1, 'h12);
    step(f_rr(0, 0, 0),  1, 0, 0, 0, ALU_PASS, 0, 1, 'h13, -1, -1, 1, 1);

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
